// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// MULT uses radix-2 Booth recoding, DIV uses restoring division on
// magnitudes with the signs applied after the final iteration.
//
// Handshake: start_mult/start_div are sampled only in IDLE (multiply wins when
// both are high); busy is high for the WIDTH iteration cycles; done pulses for
// one cycle when hi/lo (or div_zero) become valid; starts seen outside IDLE are
// dropped, never queued.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc holds the Booth partial product (MULT) or the partial remainder (DIV).
  logic [WIDTH:0]   acc_q, acc_d;
  // qr holds the multiplier being shifted out (MULT) or dividend/quotient (DIV).
  logic [WIDTH-1:0] qr_q, qr_d;
  logic             qm1_q, qm1_d;
  // m holds the sign-extended multiplicand (MULT) or divisor magnitude (DIV).
  logic [WIDTH:0]   m_q, m_d;
  logic             is_div_q, is_div_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand magnitudes, WIDTH+1 bits so the most-negative value is representable.
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;

  // One iteration of each algorithm plus the final signed results.
  logic [WIDTH:0]   mul_sum, mul_acc_n;
  logic [WIDTH-1:0] mul_qr_n;
  logic             mul_qm1_n;
  logic [WIDTH:0]   div_shift, div_acc_n;
  logic [WIDTH-1:0] div_qr_n;
  logic             div_ge;
  logic [WIDTH-1:0] div_q_fix, div_r_fix;

  // Sign-extend and take absolute values of the incoming operands.
  always_comb begin
    a_ext = {op_a[WIDTH-1], op_a};
    b_ext = {op_b[WIDTH-1], op_b};
    a_mag = op_a[WIDTH-1] ? -a_ext : a_ext;
    b_mag = op_b[WIDTH-1] ? -b_ext : b_ext;
  end

  // Single Booth step and single restoring-division step on the current state.
  always_comb begin
    mul_sum = acc_q;
    case ({qr_q[0], qm1_q})
      2'b01:   mul_sum = acc_q + m_q;
      2'b10:   mul_sum = acc_q - m_q;
      default: mul_sum = acc_q;
    endcase
    mul_acc_n = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
    mul_qr_n  = {mul_sum[0], qr_q[WIDTH-1:1]};
    mul_qm1_n = qr_q[0];

    div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    div_ge    = (div_shift >= m_q);
    div_acc_n = div_ge ? (div_shift - m_q) : div_shift;
    div_qr_n  = {qr_q[WIDTH-2:0], div_ge};
    div_q_fix = q_neg_q ? -div_qr_n : div_qr_n;
    div_r_fix = r_neg_q ? -div_acc_n[WIDTH-1:0] : div_acc_n[WIDTH-1:0];
  end

  // Control FSM: next state, operand loading, iteration and result write-back.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    qr_d       = qr_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d    = S_RUN;
          cnt_d      = CW'(WIDTH);
          div_zero_d = 1'b0;
          is_div_d   = 1'b0;
          acc_d      = '0;
          qr_d       = op_b;
          qm1_d      = 1'b0;
          m_d        = a_ext;
        end else if (start_div) begin
          if (op_b == '0) begin
            // Divide by zero: report immediately, leave HI/LO untouched.
            state_d    = S_DONE;
            div_zero_d = 1'b1;
          end else begin
            state_d    = S_RUN;
            cnt_d      = CW'(WIDTH);
            div_zero_d = 1'b0;
            is_div_d   = 1'b1;
            acc_d      = '0;
            qr_d       = a_mag[WIDTH-1:0];
            qm1_d      = 1'b0;
            m_d        = b_mag;
            q_neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_neg_d    = op_a[WIDTH-1];
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_d = div_acc_n;
          qr_d  = div_qr_n;
        end else begin
          acc_d = mul_acc_n;
          qr_d  = mul_qr_n;
          qm1_d = mul_qm1_n;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = div_r_fix;
            lo_d = div_q_fix;
          end else begin
            hi_d = mul_acc_n[WIDTH-1:0];
            lo_d = mul_qr_n;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      qr_q       <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      qr_q       <= qr_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      is_div_q   <= is_div_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign div_zero  = div_zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule
